multicycle_controller: RTL

- Control unit for the multicycle RV32I core, in the Decode stage.
- Sequences each instruction through fetch, decode, execute, memory and writeback using a Moore FSM.
- Generates ImmSrc for the SignExtend block directly downstream (00 I, 01 S, 10 B, 11 J).
- Also generates the ALU, memory, register-file and PC control strobes for the datapath.

---
 rtl/riscv_pkg.sv | 71 +++++++
 rtl/alu_decoder.sv | 39 +++
 rtl/multicycle_controller.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core.
// Contents: controller state encodings, opcodes, ALUOp codes,
// ALUControl codes, datapath select codes and the ImmSrc codes
// used by both the controller and SignExtend.
package riscv_pkg;

  localparam int ALUCTL_W = 3;
  localparam int STATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format for SignExtend, a pure function of the opcode.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE: return IMM_I;
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction fields to an ALUControl code.
// Ports:
//   alu_op_i      ALUOp from the controller FSM
//   funct3_i      instruction bits [14:12]
//   funct7b5_i    instruction bit 30
//   op5_i         opcode bit 5 (distinguishes R-type from I-type)
//   alu_control_o ALU operation select
module alu_decoder
  import riscv_pkg::*;
(
  input  aluop_e              alu_op_i,
  input  logic [2:0]          funct3_i,
  input  logic                funct7b5_i,
  input  logic                op5_i,
  output logic [ALUCTL_W-1:0] alu_control_o
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements leaves it unassigned (that infers a latch).
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // sub only for R-type with funct7[5]; addi ignores bit 30.
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit (Decode stage). A Moore FSM sequences each
// instruction through fetch/decode/execute/memory/writeback and drives the
// datapath selects and write strobes.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5 instruction fields from the instruction register
//   Zero                 ALU zero flag (qualifies beq)
//   ImmSrc               immediate format to SignExtend
//   ALUSrcA/B, ALUControl, ResultSrc, AdrSrc  datapath selects
//   IRWrite, PCWrite, RegWrite, MemWrite      write strobes
//   Illegal              one-cycle pulse in Decode on an unsupported opcode
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                Zero,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [1:0]          ResultSrc,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                Illegal
);

  state_e state_q, state_d;
  aluop_e alu_op;
  logic   ir_write, pc_update, branch, reg_write, mem_write, illegal;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its inputs from before the edge, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    AdrSrc    = 1'b0;
    alu_op    = ALUOP_ADD;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pc_update = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Precompute PC-relative target (OldPC + imm) for branches.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BEQ;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEMDATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        // PC <= target, while OldPC + 4 goes to ALUOut for the link write.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (op[5]),
    .alu_control_o (ALUControl)
  );

  assign ImmSrc = imm_src_of(op);

  // Strobes are gated by reset so an aborted instruction cannot write
  // anything during the reset cycle itself.
  assign IRWrite  = ir_write  & ~reset;
  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign Illegal  = illegal   & ~reset;

endmodule
